// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: wrap-bit pointers {wrap, addr} over a possibly non-pow2 depth.
// Pure combinational functions; widths passed at call time so both FIFO sides can share them.
package fifo_pkg;

  localparam int FIFO_N     = 16;
  localparam int FIFO_DEPTH = 26624;

  typedef logic [31:0] ptr_word_t;

  function automatic ptr_word_t addr_mask(input int n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction

  function automatic logic wrap_bit(input ptr_word_t p, input int n);
    return p[n - 1];
  endfunction

  // Last address clears the address field and flips the lap bit, skipping unused codes.
  function automatic ptr_word_t ptr_next(input ptr_word_t p, input int n, input int depth);
    ptr_word_t addr;
    addr = p & addr_mask(n);
    if (addr == ptr_word_t'(depth - 1)) begin
      return (p ^ addr) ^ (32'd1 << (n - 1));
    end
    return p + 32'd1;
  endfunction

  function automatic ptr_word_t ptr_level(input ptr_word_t wr, input ptr_word_t rd,
                                          input int n, input int depth);
    ptr_word_t wa;
    ptr_word_t ra;
    wa = wr & addr_mask(n);
    ra = rd & addr_mask(n);
    if (wrap_bit(wr, n) == wrap_bit(rd, n)) begin
      return wa - ra;
    end
    return ptr_word_t'(depth) - ra + wa;
  endfunction

  function automatic logic ptr_full(input ptr_word_t wr, input ptr_word_t rd, input int n);
    return (wrap_bit(wr, n) != wrap_bit(rd, n)) &&
           ((wr & addr_mask(n)) == (rd & addr_mask(n)));
  endfunction

  function automatic logic ptr_empty(input ptr_word_t wr, input ptr_word_t rd, input int n);
    return ((wr ^ rd) & ((32'd1 << n) - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/wrap_ptr_counter.sv
// Wrap-bit pointer counter: advances one slot per inc, lap bit toggles after address DEPTH-1.
// Result visible the cycle after inc; no backpressure, caller decides when to increment.
module wrap_ptr_counter
  import fifo_pkg::*;
#(
  parameter int N     = FIFO_N,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         inc,
  output logic [N-1:0] ptr
);

  logic [N-1:0] ptr_q;
  logic [N-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = N'(ptr_next(ptr_word_t'(ptr_q), N, DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/write_unit.sv
// FIFO write side: owns wrPtr, gates RAM writes, derives full/almost-full/level from rdPtr.
// Flags are combinational on rdPtr; wrAck lags an accepted write by one cycle; writes while full are dropped.
module write_unit
  import fifo_pkg::*;
#(
  parameter int N         = FIFO_N,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 4
) (
  input  logic         wrClk,
  input  logic         wrRstN,
  input  logic         wrEn,
  input  logic         ovfClr,
  input  logic [N-1:0] rdPtr,
  output logic [N-1:0] wrPtr,
  output logic         memWe,
  output logic [N-2:0] memAddr,
  output logic         fifoFull,
  output logic         almostFull,
  output logic [N-1:0] fillLevel,
  output logic         wrAck,
  output logic         overflow
);

  localparam logic [N-1:0] AF_LVL = N'(AF_THRESH);

  logic [N-1:0] wr_ptr;
  logic         full;
  logic         accept;
  logic [N-1:0] level;
  logic         wr_ack_q;
  logic         wr_ack_d;
  logic         overflow_q;
  logic         overflow_d;

  wrap_ptr_counter #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk  (wrClk),
    .rstN (wrRstN),
    .inc  (accept),
    .ptr  (wr_ptr)
  );

  assign full  = ptr_full(ptr_word_t'(wr_ptr), ptr_word_t'(rdPtr), N);
  assign level = N'(ptr_level(ptr_word_t'(wr_ptr), ptr_word_t'(rdPtr), N, DEPTH));

  // Reset also blocks the RAM strobe so a held-in-reset producer cannot corrupt contents.
  assign accept = wrEn & ~full & wrRstN;

  always_comb begin
    wr_ack_d   = accept;
    overflow_d = overflow_q;
    if (wrEn && full) begin
      overflow_d = 1'b1;
    end else if (ovfClr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge wrClk or negedge wrRstN) begin
    if (!wrRstN) begin
      wr_ack_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ack_q   <= wr_ack_d;
      overflow_q <= overflow_d;
    end
  end

  assign wrPtr      = wr_ptr;
  assign memWe      = accept;
  assign memAddr    = wr_ptr[N-2:0];
  assign fifoFull   = full;
  assign almostFull = (level >= AF_LVL);
  assign fillLevel  = level;
  assign wrAck      = wr_ack_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_write_unit.sv
// Bench for write_unit: small config checked every cycle against a count-based occupancy model,
// plus a default-parameter instance driven through its first address wrap.
module tb_write_unit;

  localparam int D  = 6;
  localparam int AF = 4;

  logic       wrClk = 1'b0;
  logic       wrRstN;
  logic       wrEn;
  logic       ovfClr;
  logic [3:0] rdPtr;
  logic [3:0] wrPtr;
  logic       memWe;
  logic [2:0] memAddr;
  logic       fifoFull;
  logic       almostFull;
  logic [3:0] fillLevel;
  logic       wrAck;
  logic       overflow;

  logic        b_rst_n;
  logic        b_we;
  logic        b_clr;
  logic [15:0] b_rd_ptr;
  logic [15:0] b_wr_ptr;
  logic        b_mem_we;
  logic [14:0] b_mem_addr;
  logic        b_full;
  logic        b_afull;
  logic [15:0] b_level;
  logic        b_ack;
  logic        b_ovf;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: total words written/read since reset.
  int w_cnt = 0;
  int r_cnt = 0;
  bit ack_m = 1'b0;
  bit ovf_m = 1'b0;
  bit chk_en = 1'b0;

  always #5 wrClk = ~wrClk;

  write_unit #(.N(4), .DEPTH(D), .AF_THRESH(AF)) u_small (
    .wrClk      (wrClk),
    .wrRstN     (wrRstN),
    .wrEn       (wrEn),
    .ovfClr     (ovfClr),
    .rdPtr      (rdPtr),
    .wrPtr      (wrPtr),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .fifoFull   (fifoFull),
    .almostFull (almostFull),
    .fillLevel  (fillLevel),
    .wrAck      (wrAck),
    .overflow   (overflow)
  );

  write_unit u_big (
    .wrClk      (wrClk),
    .wrRstN     (b_rst_n),
    .wrEn       (b_we),
    .ovfClr     (b_clr),
    .rdPtr      (b_rd_ptr),
    .wrPtr      (b_wr_ptr),
    .memWe      (b_mem_we),
    .memAddr    (b_mem_addr),
    .fifoFull   (b_full),
    .almostFull (b_afull),
    .fillLevel  (b_level),
    .wrAck      (b_ack),
    .overflow   (b_ovf)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pointer for a running word count: lap parity in the MSB, position within the lap below.
  function automatic logic [3:0] mptr(input int cnt);
    int lap;
    int addr;
    lap  = (cnt / D) % 2;
    addr = cnt % D;
    return {1'(lap), 3'(addr)};
  endfunction

  always @(negedge wrClk) begin
    if (chk_en && wrRstN) begin
      int         lvl;
      logic [3:0] ep;
      bit         full_e;
      lvl    = w_cnt - r_cnt;
      full_e = (lvl == D);
      ep     = mptr(w_cnt);
      check("wrPtr", 32'(wrPtr), 32'(ep));
      check("memAddr", 32'(memAddr), 32'(ep[2:0]));
      check("memWe", 32'(memWe), 32'(wrEn && !full_e));
      check("fifoFull", 32'(fifoFull), 32'(full_e));
      check("almostFull", 32'(almostFull), 32'(lvl >= AF));
      check("fillLevel", 32'(fillLevel), 32'(lvl));
      check("wrAck", 32'(wrAck), 32'(ack_m));
      check("overflow", 32'(overflow), 32'(ovf_m));
    end
  end

  // One clock of stimulus; the model advances right after the edge the DUT samples.
  task automatic cyc(input bit we, input bit clr, input bit rinc);
    int  lvl;
    bit  acc;
    wrEn   = we;
    ovfClr = clr;
    rdPtr  = mptr(r_cnt);
    @(posedge wrClk);
    lvl = w_cnt - r_cnt;
    acc = we && (lvl < D);
    if (we && lvl == D) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    ack_m = acc;
    if (rinc && r_cnt < w_cnt) r_cnt++;
    if (acc) w_cnt++;
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    wrEn   = 1'b0;
    ovfClr = 1'b0;
    rdPtr  = 4'd0;
    #2 wrRstN = 1'b0;
    #2 wrRstN = 1'b1;
    w_cnt = 0;
    r_cnt = 0;
    ack_m = 1'b0;
    ovf_m = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit we;
    bit rd;
    bit clr;

    // Reset held with a pending write.
    wrRstN   = 1'b0;
    wrEn     = 1'b1;
    ovfClr   = 1'b0;
    rdPtr    = 4'd0;
    b_rst_n  = 1'b0;
    b_we     = 1'b0;
    b_clr    = 1'b0;
    b_rd_ptr = 16'd0;
    repeat (2) @(posedge wrClk);
    #1;
    check("rst_wrPtr", 32'(wrPtr), 32'd0);
    check("rst_memWe", 32'(memWe), 32'd0);
    check("rst_level", 32'(fillLevel), 32'd0);
    check("rst_full", 32'(fifoFull), 32'd0);
    check("rst_afull", 32'(almostFull), 32'd0);
    wrRstN  = 1'b1;
    b_rst_n = 1'b1;
    #1;
    check("rel_memWe", 32'(memWe), 32'd1);
    check("rel_wrAck", 32'(wrAck), 32'd0);
    chk_en = 1'b1;
    cyc(1, 0, 0);
    check("step1_ptr", 32'(wrPtr), 32'd1);
    check("step1_ack", 32'(wrAck), 32'd1);
    cyc(1, 0, 0);
    check("step2_ptr", 32'(wrPtr), 32'd2);

    // Fill from empty; almostFull must first appear at level 4.
    do_reset();
    for (int k = 1; k <= D; k++) begin
      cyc(1, 0, 0);
      check("fill_afull", 32'(almostFull), 32'(k >= 4));
    end
    wrEn = 1'b0;
    #1;
    check("fill_ptr", 32'(wrPtr), 32'b1000);
    check("fill_full", 32'(fifoFull), 32'd1);
    check("fill_level", 32'(fillLevel), 32'd6);

    // Overflow: sticky, set beats clear.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("ovf_ptr_hold", 32'(wrPtr), 32'b1000);
    check("ovf_set", 32'(overflow), 32'd1);
    cyc(1, 1, 0);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    cyc(0, 1, 0);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Lap crossing at address DEPTH-1.
    do_reset();
    repeat (5) cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("wrap_pre_ptr", 32'(wrPtr), 32'b0101);
    check("wrap_pre_lvl", 32'(fillLevel), 32'd0);
    cyc(1, 0, 0);
    check("wrap_ptr", 32'(wrPtr), 32'b1000);
    check("wrap_lvl", 32'(fillLevel), 32'd1);
    repeat (D) cyc(1, 0, 1);
    check("lap2_ptr", 32'(wrPtr), 32'b0000);
    repeat (D) cyc(1, 0, 1);
    check("lap3_ptr", 32'(wrPtr), 32'b1000);

    // Full with a read landing the same cycle: rejected, then accepted.
    do_reset();
    repeat (3) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 1);
    repeat (D) cyc(1, 0, 0);
    wrEn  = 1'b0;
    rdPtr = mptr(r_cnt);
    #1;
    check("fr_ptr", 32'(wrPtr), 32'b1011);
    check("fr_full", 32'(fifoFull), 32'd1);
    cyc(1, 0, 1);
    check("fr_reject_ptr", 32'(wrPtr), 32'b1011);
    check("fr_reject_ovf", 32'(overflow), 32'd1);
    cyc(1, 0, 0);
    check("fr_accept_ptr", 32'(wrPtr), 32'b1100);
    check("fr_accept_ack", 32'(wrAck), 32'd1);

    // Randomized traffic against the occupancy model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      we  = ($urandom_range(0, 99) < 60);
      rd  = ($urandom_range(0, 99) < 45) && (r_cnt < w_cnt);
      clr = ($urandom_range(0, 15) == 0);
      cyc(we, clr, rd);
    end

    // Asynchronous reset between edges during a burst.
    do_reset();
    repeat (D + 1) cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    check("pre_arst_ack", 32'(wrAck), 32'd1);
    check("pre_arst_ovf", 32'(overflow), 32'd1);
    chk_en = 1'b0;
    wrEn   = 1'b1;
    #2 wrRstN = 1'b0;
    #1;
    check("arst_ptr", 32'(wrPtr), 32'd0);
    check("arst_ack", 32'(wrAck), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_memWe", 32'(memWe), 32'd0);
    wrEn = 1'b0;
    #1 wrRstN = 1'b1;

    // Default parameters: run up to and across address 26623.
    @(posedge wrClk);
    #1 b_we = 1'b1;
    repeat (26623) @(posedge wrClk);
    #1;
    check("big_pre_ptr", 32'(b_wr_ptr), 32'h67FF);
    check("big_pre_full", 32'(b_full), 32'd0);
    check("big_pre_lvl", 32'(b_level), 32'd26623);
    @(posedge wrClk);
    #1;
    b_we = 1'b0;
    #1;
    check("big_wrap_ptr", 32'(b_wr_ptr), 32'h8000);
    check("big_wrap_addr", 32'(b_mem_addr), 32'd0);
    check("big_full", 32'(b_full), 32'd1);
    check("big_lvl", 32'(b_level), 32'd26624);
    check("big_afull", 32'(b_afull), 32'd1);
    check("big_ack", 32'(b_ack), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
